cdb_wb_arbiter: RTL and testbench
=================================

Name: cdb_wb_arbiter

Overview:
Shares the single writeback port (wb_valid/wb_ready/wb_pkt) of commit_rename/ROB among N_REQ functional units (ALU, MUL, LSU, BRU).
- Each requester gets a one-entry holding buffer.
- Full buffers are arbitrated round-robin; the grant is locked while the ROB back-pressures.
- Flush drops all in-flight writebacks.

Parameters:
N_REQ, 4, number of FU requesters (2..8)
IDX_W, (N_REQ>1 ? $clog2(N_REQ) : 1), derived grant index width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
req_valid  input  N_REQ  per-FU writeback valid
req_ready  output  N_REQ  per-FU accept
req_pkt  input  N_REQ x fu_wb_t  per-FU writeback packet
wb_valid  output  1  to ROB writeback
wb_ready  input  1  from ROB writeback
wb_pkt  output  fu_wb_t  granted packet
flush_valid  input  1  pipeline flush
grant_idx  output  IDX_W  requester currently driving wb_pkt; 0 when wb_valid=0
stall_cnt  output  CNT_W  cycles with wb_valid && !wb_ready, saturating

Behaviour:
- Single clock domain. Reset is synchronous and active-low; all state updates on the clk rising edge.
- Reset state: buf_v=0, rr_ptr=0, lock_v=0, lock_idx=0, stall_cnt=0.
- Reset outputs: wb_valid=0, grant_idx=0, wb_pkt=0. req_ready=0 while rst_n=0 and all-ones the first cycle after.
- Buffer i accepts when req_valid[i] && req_ready[i]. It stores req_pkt[i] and sets buf_v[i] next cycle.
- Latency: accept at cycle T gives earliest wb_valid at T+1. There is no combinational req->wb path.
- req_ready[i] = rst_n && !flush_valid && (!buf_v[i] || (wb_valid && wb_ready && grant==i)). This gives back-to-back throughput of 1/cycle per FU; the wb_ready->req_ready combinational path is intended.
- wb_valid = |buf_v && !flush_valid.
- Grant selection:
  - If lock_v, grant = lock_idx.
  - Else grant = first i with buf_v[i], scanning from rr_ptr upward modulo N_REQ.
  - wb_pkt = buffer[grant].
- Lock: when wb_valid && !wb_ready, set lock_v=1 and lock_idx=grant. Clear lock_v on handshake or flush. wb_pkt and grant_idx must remain stable while stalled.
- Handshake (wb_valid && wb_ready):
  - buf_v[grant] clears, unless it is refilled the same cycle, in which case it stays set with the new packet.
  - rr_ptr <= (grant+1) mod N_REQ, computed with wrap, not IDX_W overflow, when N_REQ is not a power of 2.
- No handshake: rr_ptr holds.
- Flush (flush_valid=1):
  - wb_valid forced 0, no accepts.
  - Next cycle buf_v=0 and lock_v=0; rr_ptr and stall_cnt hold.
  - Reset has priority over flush.
- stall_cnt increments when wb_valid && !wb_ready and saturates at all-ones.
- Simultaneous accept and drain on the same buffer is legal. Accepts on other buffers the same cycle do not disturb the current grant.
- Fairness: with all buffers continuously full and wb_ready=1, each requester is granted exactly once per N_REQ cycles.
- Assertions:
  - wb_pkt stable while wb_valid && !wb_ready.
  - grant_idx < N_REQ.
  - onehot0 of handshake-cleared buffers.

Decomposition:
- fu_wb_t stays in the shared defines/package. Add a package constant WB_NUM_REQ=4 with the FU index assignments (ALU=0, MUL=1, LSU=2, BRU=3).
- One sub-module: rr_pick, a combinational N-way round-robin first-one finder (inputs req vector and ptr; outputs idx and found). Buffers, lock and counter stay in the top module.

Test Plan:
- Reset, then req_valid=4'b0001 with pkt.rob_idx=5 at T, wb_ready=1 -> wb_valid=1 at T+1 with rob_idx=5, grant_idx=0; req_ready[0]=1 throughout.
- All 4 buffers full, wb_ready=1 for 8 cycles, rr_ptr=0 -> grant_idx sequence 0,1,2,3,0,1,2,3 with FUs refilling each cycle.
- Buffers 1 and 3 full, wb_ready=0 for 5 cycles then 1 -> grant_idx=1 and wb_pkt stable all 5 cycles; stall_cnt=5; handshake on cycle 6, then grant_idx=3.
- Buffer 2 full and stalled, flush_valid pulse -> wb_valid=0 that cycle, req_ready=0, buf_v=0 next cycle, no wb_valid afterwards until a new req.
- N_REQ=3, all full, grant=2 handshake -> rr_ptr wraps to 0, next grant_idx=0.
- Drive rst_n=0 for 1 cycle mid-stall with 3 buffers full -> next cycle wb_valid=0, stall_cnt=0, rr_ptr=0.

Source files
------------

// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared types for the writeback path between the functional units and the ROB.
//   fu_wb_t    : one functional-unit writeback packet
//   WB_NUM_REQ : number of writeback requesters in the default core config
//   FU_*       : requester index of each functional unit on the arbiter
package cdb_wb_arbiter_pkg;

    typedef struct packed {
        logic        exc;       // result raised an exception
        logic [5:0]  rob_idx;   // ROB entry being completed
        logic [31:0] data;      // result value
    } fu_wb_t;

    localparam int WB_NUM_REQ = 4;

    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LSU = 2;
    localparam int FU_BRU = 3;

endpackage

// File: rtl/cdb_wb_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
//   req   : request vector
//   ptr   : index the scan starts from (wraps modulo N_REQ)
//   idx   : first set request at or after ptr
//   found : any request set
module cdb_wb_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // Wrap by subtraction so non-power-of-two N_REQ scans correctly.
            int j;
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Writeback arbiter: N_REQ functional units share the single ROB writeback port.
// Each unit owns a one-entry holding buffer; full buffers are granted
// round-robin, and the grant is locked while the ROB back-pressures.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/ready/pkt   : per-FU writeback request (one-entry buffer each)
//   wb_valid/ready/pkt    : granted packet towards the ROB
//   flush_valid           : drops every buffered writeback
//   grant_idx             : requester driving wb_pkt (0 when idle)
//   stall_cnt             : saturating count of back-pressured cycles
module cdb_wb_arbiter import cdb_wb_arbiter_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  fu_wb_t [N_REQ-1:0]     req_pkt,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output fu_wb_t                 wb_pkt,
    input  logic                   flush_valid,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [N_REQ-1:0]   buf_v;
    fu_wb_t [N_REQ-1:0] buf_pkt;
    logic [IDX_W-1:0]   rr_ptr;
    logic               lock_v;
    logic [IDX_W-1:0]   lock_idx;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   grant;
    logic               hs;
    logic [N_REQ-1:0]   hs_clr;
    logic [N_REQ-1:0]   accept;

    cdb_wb_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req   (buf_v),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A stalled grant stays put so wb_pkt cannot change under back-pressure.
    assign grant     = lock_v ? lock_idx : pick_idx;
    assign wb_valid  = rst_n && pick_found && !flush_valid;
    assign hs        = wb_valid && wb_ready;
    assign grant_idx = wb_valid ? grant : '0;
    assign wb_pkt    = wb_valid ? buf_pkt[grant] : '0;
    assign hs_clr    = hs ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant) : '0;

    // Draining buffer may refill in the same cycle: wb_ready feeds req_ready.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = rst_n && !flush_valid && (!buf_v[i] || hs_clr[i]);
    end
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_v     <= '0;
            buf_pkt   <= '0;
            rr_ptr    <= '0;
            lock_v    <= 1'b0;
            lock_idx  <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_valid) begin
                buf_v  <= '0;
                lock_v <= 1'b0;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (accept[i]) begin
                        buf_v[i]   <= 1'b1;
                        buf_pkt[i] <= req_pkt[i];
                    end else if (hs_clr[i]) begin
                        buf_v[i] <= 1'b0;
                    end
                end
                if (hs) begin
                    lock_v <= 1'b0;
                    rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                end else if (wb_valid) begin
                    lock_v   <= 1'b1;
                    lock_idx <= grant;
                end
            end
            if (wb_valid && !wb_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    a_pkt_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && !wb_ready) |=> (!rst_n || flush_valid || $stable(wb_pkt)));
    a_grant_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(grant_idx) < N_REQ);
    a_clr_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(hs_clr));

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
module tb_cdb_wb_arbiter;
    import cdb_wb_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready;
    fu_wb_t [N-1:0] req_pkt;
    logic           wb_valid, wb_ready, flush_valid;
    fu_wb_t         wb_pkt;
    logic [1:0]     grant_idx;
    logic [15:0]    stall_cnt;

    logic [2:0]     req_valid3, req_ready3;
    fu_wb_t [2:0]   req_pkt3;
    logic           wb_valid3, wb_ready3, flush_valid3;
    fu_wb_t         wb_pkt3;
    logic [1:0]     grant_idx3;
    logic [15:0]    stall_cnt3;

    cdb_wb_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_pkt(req_pkt), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pkt(wb_pkt),
        .flush_valid(flush_valid), .grant_idx(grant_idx), .stall_cnt(stall_cnt)
    );

    cdb_wb_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_pkt(req_pkt3), .wb_valid(wb_valid3), .wb_ready(wb_ready3), .wb_pkt(wb_pkt3),
        .flush_valid(flush_valid3), .grant_idx(grant_idx3), .stall_cnt(stall_cnt3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] idx;
        fu_wb_t     pkt;
    } exp_t;
    exp_t sb[$];

    function automatic fu_wb_t mk(int fu, int seq);
        fu_wb_t p;
        p.exc     = 1'((fu + seq) & 1);
        p.rob_idx = 6'((fu * 13 + seq) % 64);
        p.data    = 32'(fu * 1000 + seq + 32'h5a00_0000);
        return p;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = '0; req_pkt = '0; wb_ready = 1'b0; flush_valid = 1'b0;
        req_valid3 = '0; req_pkt3 = '0; wb_ready3 = 1'b0; flush_valid3 = 1'b0;
        sb.delete();
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        rst_n = 1'b0;
        step; step;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0 || wb_valid !== 1'b0 || grant_idx !== 2'd0 ||
            wb_pkt !== '0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b idx=%0d pkt=%h stall=%0d expected 0,0,0,0,0",
                     req_ready, wb_valid, grant_idx, wb_pkt, stall_cnt);
        end
        step;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'hf || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b expected 1111,0", req_ready, wb_valid);
        end
        step;
    endtask

    task automatic test_single;
        fu_wb_t p;
        exp_t e;
        do_reset;
        p = mk(0, 0);
        p.rob_idx = 6'd5;
        wb_ready = 1'b1;
        req_valid = 4'b0001;
        req_pkt[0] = p;
        sb.push_back('{idx: 2'd0, pkt: p});
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: ready0=%b valid=%b expected 1,0", req_ready[0], wb_valid);
        end
        step;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL single_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt || req_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_out: valid=%b idx=%0d pkt=%h ready0=%b expected 1 idx=%0d pkt=%h ready0=1",
                         wb_valid, grant_idx, wb_pkt, req_ready[0], e.idx, e.pkt);
            end
        end
        step;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: valid=%b expected 0", wb_valid);
        end
        step;
    endtask

    task automatic test_round_robin;
        exp_t e;
        do_reset;
        wb_ready = 1'b1;
        req_valid = 4'hf;
        for (int i = 0; i < N; i++) begin
            req_pkt[i] = mk(i, 0);
            sb.push_back('{idx: 2'(i), pkt: mk(i, 0)});
        end
        @(negedge clk);
        step;
        // Every FU keeps offering; only the granted one refills each cycle.
        for (int k = 1; k <= 8; k++) begin
            int g;
            g = (k - 1) % N;
            for (int i = 0; i < N; i++) req_pkt[i] = mk(i, k);
            sb.push_back('{idx: 2'(g), pkt: mk(g, k)});
            @(negedge clk);
            checks++;
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt ||
                req_ready !== 4'(1 << g)) begin
                errors++;
                $display("FAIL rr_cycle%0d: valid=%b idx=%0d pkt=%h ready=%b expected idx=%0d pkt=%h ready=%b",
                         k, wb_valid, grant_idx, wb_pkt, req_ready, e.idx, e.pkt, 4'(1 << g));
            end
            step;
        end
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rr_drain%0d: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt) begin
                    errors++;
                    $display("FAIL rr_drain%0d: valid=%b idx=%0d pkt=%h expected idx=%0d pkt=%h",
                             k, wb_valid, grant_idx, wb_pkt, e.idx, e.pkt);
                end
            end
            step;
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_empty: valid=%b left=%0d expected 0,0", wb_valid, sb.size());
        end
        step;
    endtask

    task automatic test_stall_lock;
        exp_t e;
        do_reset;
        wb_ready = 1'b0;
        req_valid = 4'b1010;
        req_pkt[1] = mk(1, 1);
        req_pkt[3] = mk(3, 1);
        sb.push_back('{idx: 2'd1, pkt: mk(1, 1)});
        sb.push_back('{idx: 2'd3, pkt: mk(3, 1)});
        step;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            // FU0 fills mid-stall; the locked grant must not move to it.
            if (c == 2) begin
                req_valid = 4'b0001;
                req_pkt[0] = mk(0, 7);
            end
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b1 || grant_idx !== 2'd1 || wb_pkt !== mk(1, 1) ||
                (c == 2 && req_ready[0] !== 1'b1)) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b idx=%0d pkt=%h ready=%b expected 1 idx=1 pkt=%h",
                         c, wb_valid, grant_idx, wb_pkt, req_ready, mk(1, 1));
            end
            step;
            req_valid = '0;
        end
        sb.push_back('{idx: 2'd0, pkt: mk(0, 7)});
        wb_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_count: stall_cnt=%0d expected 5", stall_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt) begin
                errors++;
                $display("FAIL stall_drain%0d: valid=%b idx=%0d pkt=%h expected idx=%0d pkt=%h",
                         k, wb_valid, grant_idx, wb_pkt, e.idx, e.pkt);
            end
            step;
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_after: valid=%b stall_cnt=%0d expected 0,5", wb_valid, stall_cnt);
        end
        step;
    endtask

    task automatic test_flush;
        exp_t e;
        do_reset;
        wb_ready = 1'b0;
        req_valid = 4'b0100;
        req_pkt[2] = mk(2, 3);
        step;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre: valid=%b idx=%0d expected 1,2", wb_valid, grant_idx);
        end
        step;
        flush_valid = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 4'h0) begin
            errors++;
            $display("FAIL flush_cycle: valid=%b ready=%b expected 0,0000", wb_valid, req_ready);
        end
        step;
        flush_valid = 1'b0;
        req_valid = '0;
        wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0 || stall_cnt !== 16'd1) begin
                errors++;
                $display("FAIL flush_after%0d: valid=%b stall_cnt=%0d expected 0,1", c, wb_valid, stall_cnt);
            end
            step;
        end
        req_valid = 4'b0010;
        req_pkt[1] = mk(1, 4);
        sb.push_back('{idx: 2'd1, pkt: mk(1, 4)});
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_newreq_comb: valid=%b expected 0", wb_valid);
        end
        step;
        req_valid = '0;
        @(negedge clk);
        checks++;
        e = sb.pop_front();
        if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt) begin
            errors++;
            $display("FAIL flush_newreq: valid=%b idx=%0d pkt=%h expected idx=%0d pkt=%h",
                     wb_valid, grant_idx, wb_pkt, e.idx, e.pkt);
        end
        step;
    endtask

    task automatic test_wrap3;
        do_reset;
        wb_ready3 = 1'b1;
        req_valid3 = 3'b111;
        for (int i = 0; i < 3; i++) req_pkt3[i] = mk(i, 0);
        step;
        for (int k = 1; k <= 6; k++) begin
            int g;
            fu_wb_t p;
            g = (k - 1) % 3;
            p = (k <= 3) ? mk(g, 0) : mk(g, k - 3);
            for (int i = 0; i < 3; i++) req_pkt3[i] = mk(i, k);
            @(negedge clk);
            checks++;
            if (wb_valid3 !== 1'b1 || grant_idx3 !== 2'(g) || wb_pkt3 !== p) begin
                errors++;
                $display("FAIL wrap3_cycle%0d: valid=%b idx=%0d pkt=%h expected idx=%0d pkt=%h",
                         k, wb_valid3, grant_idx3, wb_pkt3, g, p);
            end
            step;
        end
        req_valid3 = '0;
    endtask

    task automatic test_reset_mid_stall;
        exp_t e;
        do_reset;
        wb_ready = 1'b0;
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) req_pkt[i] = mk(i, 2);
        step;
        req_valid = '0;
        wb_ready = 1'b1;
        step;               // FU0 drains, rr_ptr moves to 1
        wb_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b1 || grant_idx !== 2'd1) begin
                errors++;
                $display("FAIL rst_stall%0d: valid=%b idx=%0d expected 1,1", c, wb_valid, grant_idx);
            end
            step;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 4'h0) begin
            errors++;
            $display("FAIL rst_during: valid=%b ready=%b expected 0,0000", wb_valid, req_ready);
        end
        step;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || stall_cnt !== 16'd0 || req_ready !== 4'hf) begin
            errors++;
            $display("FAIL rst_after: valid=%b stall_cnt=%0d ready=%b expected 0,0,1111",
                     wb_valid, stall_cnt, req_ready);
        end
        // FU0 before FU3 only if the round-robin pointer went back to 0.
        wb_ready = 1'b1;
        req_valid = 4'b1001;
        req_pkt[0] = mk(0, 9);
        req_pkt[3] = mk(3, 9);
        sb.push_back('{idx: 2'd0, pkt: mk(0, 9)});
        sb.push_back('{idx: 2'd3, pkt: mk(3, 9)});
        step;
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || grant_idx !== e.idx || wb_pkt !== e.pkt) begin
                errors++;
                $display("FAIL rst_rrptr%0d: valid=%b idx=%0d pkt=%h expected idx=%0d pkt=%h",
                         k, wb_valid, grant_idx, wb_pkt, e.idx, e.pkt);
            end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_stall_lock;
        test_flush;
        test_wrap3;
        test_reset_mid_stall;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
